motor_protect_ctrl: RTL
=======================

MOTOR_PROTECT_CTRL -- requirements
Module: motor_protect_ctrl

Interface
REQ-001 Parameter OC_FILTER_CYCLES, default 20000000: consecutive overcurrent cycles needed to trip a channel.
REQ-002 Parameter COOLDOWN_CYCLES, default 100000000: cycles a tripped channel stays off before retry.
REQ-003 Parameter STAGGER_CYCLES, default 5000000: minimum cycles between two motor start grants.
REQ-004 Parameter MAX_RETRIES, default 3: trips tolerated before lockout (range 1..3).
REQ-005 clock  in  1  single system clock, all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 run_a, run_b  in  1 each  drive-logic run requests for motor A / motor B (levels).
REQ-008 ia, ib  in  1 each  raw overcurrent comparator outputs for motor A / motor B.
REQ-009 clear_btn  in  1  debounced, synchronized operator clear (level).
REQ-010 en_a, en_b  out  1 each  motor driver enables.
REQ-011 fault_a, fault_b  out  1 each  channel in lockout.
REQ-012 retry_a, retry_b  out  2 each  current trip count per channel.
REQ-013 oc  out  1  OR of all channels in cooldown or lockout.

Function
REQ-014 Each channel SHALL run an independent FSM: IDLE, WAIT_GRANT, RUN, COOL, LOCK.
REQ-015 IDLE: run_x high -> WAIT_GRANT next edge; en_x low.
REQ-016 WAIT_GRANT: SHALL move to RUN on the edge a start grant is issued; run_x low -> IDLE.
REQ-017 The start arbiter SHALL issue at most one grant per cycle, only when its stagger counter is zero, then load STAGGER_CYCLES and count down to zero.
REQ-018 Both channels waiting in the same cycle: grant to the channel not granted most recently (round-robin); A wins the first tie after reset.
REQ-019 RUN: en_x high (registered, first high cycle is the cycle after entry); run_x low -> IDLE and retry_x cleared.
REQ-020 RUN filter: counter increments each cycle ix high, clears to 0 on any cycle ix low; it is only active in RUN.
REQ-021 Trip: on the edge the filter counter reaches OC_FILTER_CYCLES, en_x SHALL be low from that edge, retry_x increments, filter clears.
REQ-022 Trip with incremented retry_x < MAX_RETRIES -> COOL; retry_x = MAX_RETRIES -> LOCK.
REQ-023 COOL: en_x low, counter runs COOLDOWN_CYCLES cycles regardless of ix/run_x; at expiry -> WAIT_GRANT if run_x high else IDLE.
REQ-024 LOCK: en_x low, fault_x high; exits to IDLE only on clear_btn high, retry_x cleared same edge.
REQ-025 clear_btn high in IDLE, WAIT_GRANT, RUN or COOL SHALL clear retry_x and nothing else.
REQ-026 Simultaneous trip and clear_btn: trip wins; retry_x increments, clear ignored that cycle.
REQ-027 All counters SHALL be wide enough to hold their parameter value without wrap; retry_x saturates at MAX_RETRIES.
REQ-028 oc SHALL be registered: high the cycle after any channel enters COOL or LOCK.

Reset
REQ-029 reset high SHALL, at the next edge, force both FSMs to IDLE, all counters to 0, round-robin pointer to A.
REQ-030 Reset values: en_a=en_b=0, fault_a=fault_b=0, retry_a=retry_b=0, oc=0.
REQ-031 reset asserted mid-RUN or mid-COOL SHALL drop en_x on that edge; no state survives reset.

Structure
REQ-032 FSM state encoding and default parameter constants SHALL live in shared package motor_protect_pkg.
REQ-033 One per-channel sub-module oc_channel (FSM, filter, cooldown, retry counter) SHALL be instantiated twice; arbiter lives in the top.

Verification (OC_FILTER_CYCLES=4, COOLDOWN_CYCLES=8, STAGGER_CYCLES=3, MAX_RETRIES=3)
REQ-034 run_a and run_b rise together -> en_a high 2 cycles later, en_b high exactly 3 cycles after en_a.
REQ-035 In RUN, ia high 3 cycles, low 1, high 3 -> no trip; ia high 4 consecutive -> en_a low on 4th edge, retry_a=1, oc high next cycle.
REQ-036 Hold ia high continuously with run_a high -> three trips separated by 8-cycle cooldowns, then fault_a=1, retry_a=3, en_a stays 0 until clear_btn pulse returns to IDLE.
REQ-037 clear_btn high on the same cycle as 3rd trip -> LOCK entered, fault_a=1; later clear_btn -> IDLE, retry_a=0.
REQ-038 reset pulsed while en_b=1 and A in COOL -> next cycle all outputs 0; release with run_a,run_b high -> A granted first.
REQ-039 Trip on B while A running -> en_a unaffected, fault_a=0, oc=1.

Source files
------------

// File: rtl/motor_protect_pkg.sv
// Shared definitions for the two-channel motor protection controller:
// per-channel state encoding, default timing constants and a counter-width helper.
package motor_protect_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_GRANT = 3'd1,
        ST_RUN        = 3'd2,
        ST_COOL       = 3'd3,
        ST_LOCK       = 3'd4
    } ch_state_e;

    localparam int DEF_OC_FILTER_CYCLES = 20000000;
    localparam int DEF_COOLDOWN_CYCLES  = 100000000;
    localparam int DEF_STAGGER_CYCLES   = 5000000;
    localparam int DEF_MAX_RETRIES      = 3;

    // Bits needed to hold max_val without wrapping (never less than one).
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/oc_channel.sv
// One motor channel: run/grant sequencing, overcurrent filter, cooldown timer,
// trip counter and lockout.
module oc_channel
    import motor_protect_pkg::*;
#(
    parameter int OC_FILTER_CYCLES = DEF_OC_FILTER_CYCLES,
    parameter int COOLDOWN_CYCLES  = DEF_COOLDOWN_CYCLES,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       ix,
    input  logic       clear_btn,
    input  logic       grant,
    output logic       req,
    output logic       en,
    output logic       fault,
    output logic [1:0] retry,
    output logic       oc_next
);

    localparam int FW = cnt_width(OC_FILTER_CYCLES);
    localparam int CW = cnt_width(COOLDOWN_CYCLES);
    localparam logic [FW-1:0] FILT_LAST = FW'(OC_FILTER_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [1:0]    MAX_R     = 2'(MAX_RETRIES);

    ch_state_e     state_q, state_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [CW-1:0] cool_q, cool_d;
    logic [1:0]    retry_q, retry_d;
    logic          en_q, en_d;
    logic          fault_q, fault_d;
    logic          trip;
    logic [1:0]    retry_inc;

    always_comb begin
        state_d   = state_q;
        filt_d    = '0;
        cool_d    = '0;
        retry_d   = retry_q;
        trip      = (state_q == ST_RUN) && ix && (filt_q == FILT_LAST);
        retry_inc = (retry_q >= MAX_R) ? MAX_R : retry_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (clear_btn) retry_d = '0;
                if (run) state_d = ST_WAIT_GRANT;
            end
            ST_WAIT_GRANT: begin
                if (clear_btn) retry_d = '0;
                if (!run) state_d = ST_IDLE;
                else if (grant) state_d = ST_RUN;
            end
            ST_RUN: begin
                // A trip outranks both a simultaneous clear and a dropped run request.
                if (trip) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == MAX_R) ? ST_LOCK : ST_COOL;
                end else begin
                    if (ix) filt_d = filt_q + 1'b1;
                    if (clear_btn || !run) retry_d = '0;
                    if (!run) state_d = ST_IDLE;
                end
            end
            ST_COOL: begin
                if (clear_btn) retry_d = '0;
                if (cool_q == COOL_LAST) state_d = run ? ST_WAIT_GRANT : ST_IDLE;
                else cool_d = cool_q + 1'b1;
            end
            ST_LOCK: begin
                if (clear_btn) begin
                    retry_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        en_d    = (state_d == ST_RUN);
        fault_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            filt_q  <= '0;
            cool_q  <= '0;
            retry_q <= '0;
            en_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            cool_q  <= cool_d;
            retry_q <= retry_d;
            en_q    <= en_d;
            fault_q <= fault_d;
        end
    end

    assign req     = (state_q == ST_WAIT_GRANT) && run;
    assign en      = en_q;
    assign fault   = fault_q;
    assign retry   = retry_q;
    assign oc_next = (state_d == ST_COOL) || (state_d == ST_LOCK);

endmodule

// File: rtl/motor_protect_ctrl.sv
// Two-motor protection controller: two oc_channel instances sharing a
// round-robin start arbiter with a minimum spacing between start grants.
module motor_protect_ctrl
    import motor_protect_pkg::*;
#(
    parameter int OC_FILTER_CYCLES = DEF_OC_FILTER_CYCLES,
    parameter int COOLDOWN_CYCLES  = DEF_COOLDOWN_CYCLES,
    parameter int STAGGER_CYCLES   = DEF_STAGGER_CYCLES,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run_a,
    input  logic       run_b,
    input  logic       ia,
    input  logic       ib,
    input  logic       clear_btn,
    output logic       en_a,
    output logic       en_b,
    output logic       fault_a,
    output logic       fault_b,
    output logic [1:0] retry_a,
    output logic [1:0] retry_b,
    output logic       oc
);

    localparam int SW = cnt_width(STAGGER_CYCLES);
    // The grant cycle itself counts toward the spacing, so reload one short.
    localparam logic [SW-1:0] STAG_LOAD = SW'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);

    logic [1:0] run_v, ix_v, req_v, grant_v, en_v, fault_v, oc_next_v;
    logic [1:0] retry_v [2];

    logic [SW-1:0] stagger_q, stagger_d;
    logic          prio_b_q, prio_b_d;
    logic          oc_q, oc_d;
    logic          grant_ok;

    assign run_v = {run_b, run_a};
    assign ix_v  = {ib, ia};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            oc_channel #(
                .OC_FILTER_CYCLES (OC_FILTER_CYCLES),
                .COOLDOWN_CYCLES  (COOLDOWN_CYCLES),
                .MAX_RETRIES      (MAX_RETRIES)
            ) u_ch (
                .clock     (clock),
                .reset     (reset),
                .run       (run_v[gi]),
                .ix        (ix_v[gi]),
                .clear_btn (clear_btn),
                .grant     (grant_v[gi]),
                .req       (req_v[gi]),
                .en        (en_v[gi]),
                .fault     (fault_v[gi]),
                .retry     (retry_v[gi]),
                .oc_next   (oc_next_v[gi])
            );
        end
    endgenerate

    always_comb begin
        grant_ok   = (stagger_q == '0);
        grant_v[0] = grant_ok && req_v[0] && (!req_v[1] || !prio_b_q);
        grant_v[1] = grant_ok && req_v[1] && (!req_v[0] || prio_b_q);

        stagger_d = stagger_q;
        if (|grant_v) stagger_d = STAG_LOAD;
        else if (stagger_q != '0) stagger_d = stagger_q - 1'b1;

        prio_b_d = prio_b_q;
        if (grant_v[0]) prio_b_d = 1'b1;
        else if (grant_v[1]) prio_b_d = 1'b0;

        oc_d = |oc_next_v;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stagger_q <= '0;
            prio_b_q  <= 1'b0;
            oc_q      <= 1'b0;
        end else begin
            stagger_q <= stagger_d;
            prio_b_q  <= prio_b_d;
            oc_q      <= oc_d;
        end
    end

    assign en_a    = en_v[0];
    assign en_b    = en_v[1];
    assign fault_a = fault_v[0];
    assign fault_b = fault_v[1];
    assign retry_a = retry_v[0];
    assign retry_b = retry_v[1];
    assign oc      = oc_q;

endmodule
